mem_stage_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register. It takes the registered EX/MEM control and data, resolves the branch decision and drives a multi-cycle data-memory request/acknowledge interface. It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB outputs for write-back.

---
 rtl/mem_stage_unit.sv | 144 ++++++++++++++
 tb/tb_mem_stage_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: resolves branches, runs a multi-cycle data-memory
// request/acknowledge handshake with timeout, and registers MEM/WB outputs.
module mem_stage_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        Branch_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        BeqBne_i,
    input  logic        zero_i,
    input  logic [31:0] program_after_branch_i,
    input  logic [31:0] ALU_Shifter_result_i,
    input  logic [31:0] readData2_i,
    input  logic [4:0]  writeReg_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        PCSrc_o,
    output logic [31:0] branch_target_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] read_data_o,
    output logic [31:0] ALU_result_o,
    output logic [4:0]  writeReg_addr_o,
    output logic        err_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          abort_reg, abort_next;
    logic          err_reg, err_next;
    logic          access;
    logic          is_load;
    logic          stall;

    assign access  = MemRead_i | MemWrite_i;
    // A simultaneous read+write is treated as a write, so it never returns data.
    assign is_load = MemRead_i & ~MemWrite_i;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        abort_next = abort_reg;
        err_next   = err_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    stall      = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = '0;
                    abort_next = 1'b0;
                end
            end
            ACCESS: begin
                stall    = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (mem_ack_i) begin
                    rdata_next = mem_rdata_i;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    rdata_next = '0;
                    abort_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
                abort_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            abort_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            abort_reg <= abort_next;
            err_reg   <= err_next;
        end
    end

    // MEM/WB register: a stall cycle becomes a bubble, data fields hold.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_o      <= 1'b0;
            MemtoReg_o      <= 1'b0;
            read_data_o     <= '0;
            ALU_result_o    <= '0;
            writeReg_addr_o <= '0;
        end else if (!stall) begin
            RegWrite_o      <= RegWrite_i & ~((state_reg == DONE) & abort_reg);
            MemtoReg_o      <= MemtoReg_i;
            read_data_o     <= (is_load && state_reg == DONE) ? rdata_reg : 32'd0;
            ALU_result_o    <= ALU_Shifter_result_i;
            writeReg_addr_o <= writeReg_addr_i;
        end else begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
        end
    end

    assign mem_req_o       = (state_reg == ACCESS);
    assign mem_we_o        = MemWrite_i;
    assign mem_addr_o      = ALU_Shifter_result_i;
    assign mem_wdata_o     = readData2_i;
    assign stall_o         = stall;
    assign err_o           = err_reg;
    assign PCSrc_o         = Branch_i & (zero_i ^ BeqBne_i) & ~stall;
    assign branch_target_o = program_after_branch_i;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: expected MEM/WB records are queued at
// issue time and compared once the stage releases the instruction.
module tb_mem_stage_unit;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i;
    logic        BeqBne_i, zero_i;
    logic [31:0] program_after_branch_i, ALU_Shifter_result_i, readData2_i;
    logic [4:0]  writeReg_addr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, PCSrc_o;
    logic [31:0] branch_target_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] read_data_o, ALU_result_o;
    logic [4:0]  writeReg_addr_o;
    logic        err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic err_exp  = 1'b0;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wa;
        int          stall_cnt;
        int          req_cnt;
    } exp_t;
    exp_t sb_q[$];

    mem_stage_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .Branch_i(Branch_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .BeqBne_i(BeqBne_i),
        .zero_i(zero_i), .program_after_branch_i(program_after_branch_i),
        .ALU_Shifter_result_i(ALU_Shifter_result_i), .readData2_i(readData2_i),
        .writeReg_addr_i(writeReg_addr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .PCSrc_o(PCSrc_o), .branch_target_o(branch_target_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .read_data_o(read_data_o),
        .ALU_result_o(ALU_result_o), .writeReg_addr_o(writeReg_addr_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_idle();
        RegWrite_i = 0; MemtoReg_i = 0; Branch_i = 0; MemRead_i = 0; MemWrite_i = 0;
        BeqBne_i = 0; zero_i = 0; program_after_branch_i = 0; ALU_Shifter_result_i = 0;
        readData2_i = 0; writeReg_addr_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    endtask

    // Issues one instruction; ack_k = ACCESS cycle that gets the ack, 0 = never.
    task automatic run_instr(input string name, input logic rw, input logic m2r,
                             input logic br, input logic mr, input logic mw,
                             input logic bne, input logic zero, input logic [31:0] target,
                             input logic [31:0] alu, input logic [31:0] wdata,
                             input logic [4:0] wa, input int ack_k, input logic [31:0] rdata);
        exp_t e;
        logic acc, abort, pc_exp;
        int   stall_cnt, req_cnt, acc_cycles;
        bit   done;
        acc   = mr | mw;
        abort = acc && (ack_k == 0);
        e.rw  = rw & ~abort;
        e.m2r = m2r;
        e.rd  = (mr && !mw && !abort) ? rdata : 32'd0;
        e.alu = alu;
        e.wa  = wa;
        e.stall_cnt = !acc ? 0 : (abort ? TIMEOUT + 1 : ack_k + 1);
        e.req_cnt   = !acc ? 0 : (abort ? TIMEOUT : ack_k);
        if (abort) err_exp = 1'b1;
        sb_q.push_back(e);
        pc_exp = br & (zero ^ bne) & ~acc;

        @(negedge clk_i);
        RegWrite_i = rw; MemtoReg_i = m2r; Branch_i = br; MemRead_i = mr; MemWrite_i = mw;
        BeqBne_i = bne; zero_i = zero; program_after_branch_i = target;
        ALU_Shifter_result_i = alu; readData2_i = wdata; writeReg_addr_i = wa;
        #1;
        n_checks++;
        if (PCSrc_o !== pc_exp) begin
            n_fail++; $display("FAIL %s pcsrc: got %b exp %b", name, PCSrc_o, pc_exp);
        end
        n_checks++;
        if (branch_target_o !== target) begin
            n_fail++; $display("FAIL %s target: got %h exp %h", name, branch_target_o, target);
        end

        stall_cnt = 0; req_cnt = 0; acc_cycles = 0; done = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) begin @(negedge clk_i); #1; end
            if (mem_req_o === 1'b1) begin
                req_cnt++; acc_cycles++;
                n_checks++;
                if (mem_we_o !== mw || mem_addr_o !== alu || mem_wdata_o !== wdata) begin
                    n_fail++;
                    $display("FAIL %s memif: got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                             name, mem_we_o, mem_addr_o, mem_wdata_o, mw, alu, wdata);
                end
                if (acc_cycles == ack_k) begin mem_ack_i = 1; mem_rdata_i = rdata; end
            end
            if (stall_o === 1'b1) begin
                stall_cnt++;
                if (br) begin
                    n_checks++;
                    if (PCSrc_o !== 1'b0) begin
                        n_fail++; $display("FAIL %s pcsrc_stall: got %b exp 0", name, PCSrc_o);
                    end
                end
            end else begin
                done = 1;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 0; mem_rdata_i = $urandom;
            if (!done) begin
                n_checks++;
                if (RegWrite_o !== 1'b0 || MemtoReg_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s bubble: got rw=%b m2r=%b exp 0 0", name, RegWrite_o, MemtoReg_o);
                end
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL %s hang: stall still %b after 64 cycles, exp 0", name, stall_o);
        end

        e = sb_q.pop_front();
        n_checks++;
        if (RegWrite_o !== e.rw || MemtoReg_o !== e.m2r || read_data_o !== e.rd ||
            ALU_result_o !== e.alu || writeReg_addr_o !== e.wa) begin
            n_fail++;
            $display("FAIL %s memwb: got rw=%b m2r=%b rd=%h alu=%h wa=%0d exp rw=%b m2r=%b rd=%h alu=%h wa=%0d",
                     name, RegWrite_o, MemtoReg_o, read_data_o, ALU_result_o, writeReg_addr_o,
                     e.rw, e.m2r, e.rd, e.alu, e.wa);
        end
        n_checks++;
        if (stall_cnt != e.stall_cnt || req_cnt != e.req_cnt) begin
            n_fail++;
            $display("FAIL %s cycles: got stall=%0d req=%0d exp stall=%0d req=%0d",
                     name, stall_cnt, req_cnt, e.stall_cnt, e.req_cnt);
        end
        n_checks++;
        if (err_o !== err_exp) begin
            n_fail++; $display("FAIL %s err: got %b exp %b", name, err_o, err_exp);
        end
        $display("%s: stall=%0d req=%0d rw=%b rd=%h alu=%h err=%b",
                 name, stall_cnt, req_cnt, RegWrite_o, read_data_o, ALU_result_o, err_o);
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (mem_req_o !== 0 || stall_o !== 0 || RegWrite_o !== 0 || MemtoReg_o !== 0 ||
            read_data_o !== 0 || ALU_result_o !== 0 || writeReg_addr_o !== 0 || err_o !== 0) begin
            n_fail++;
            $display("FAIL reset: got req=%b stall=%b rw=%b m2r=%b rd=%h alu=%h wa=%0d err=%b exp all 0",
                     mem_req_o, stall_o, RegWrite_o, MemtoReg_o, read_data_o, ALU_result_o,
                     writeReg_addr_o, err_o);
        end
        rst_n = 1;
        $display("reset: outputs cleared");
    endtask

    task automatic test_rtype();
        run_instr("rtype", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0);
    endtask

    task automatic test_load();
        run_instr("load", 1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0040, 32'h0, 5'd7, 1, 32'hDEAD_BEEF);
    endtask

    task automatic test_store();
        run_instr("store", 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0000_0080, 32'h1234_5678, 5'd0, 3, 32'hFFFF_0000);
        run_instr("rw_both", 1, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0084, 32'h0BAD_F00D, 5'd9, 2, 32'h5555_AAAA);
    endtask

    task automatic test_timeout();
        run_instr("timeout", 1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0100, 32'h0, 5'd12, 0, 32'h0);
        run_instr("after_to", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_00AA, 32'h0, 5'd13, 0, 32'h0);
    endtask

    task automatic test_branch();
        run_instr("beq_take", 0, 0, 1, 0, 0, 0, 1, 32'h0000_2000, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        run_instr("bne_not", 0, 0, 1, 0, 0, 1, 1, 32'h0000_3000, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        run_instr("bne_take", 0, 0, 1, 0, 0, 1, 0, 32'h0000_3004, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        run_instr("br_stall", 1, 1, 1, 1, 0, 0, 1, 32'h0000_4000, 32'h0000_0044, 32'h0, 5'd3, 2, 32'h0F0F_0F0F);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            a = $urandom; d = $urandom;
            run_instr("b2b_ld", 1, 1, 0, 1, 0, 0, 0, 32'h0, a, 32'h0, 5'(i + 20), i + 1, d);
            run_instr("b2b_alu", 1, 0, 0, 0, 0, 0, 0, 32'h0, d ^ a, 32'h0, 5'(i + 1), 0, 32'h0);
        end
    endtask

    task automatic test_reset_mid_access();
        int guard;
        run_instr("pre_rst", 1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0200, 32'h0, 5'd17, 1, 32'hCAFE_F00D);
        @(negedge clk_i);
        RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; ALU_Shifter_result_i = 32'h0000_0300;
        writeReg_addr_i = 5'd18;
        guard = 0;
        #1;
        while (mem_req_o !== 1'b1 && guard < 8) begin @(negedge clk_i); #1; guard++; end
        @(negedge clk_i);
        rst_n = 0;
        #1;
        n_checks++;
        if (mem_req_o !== 0 || RegWrite_o !== 0 || MemtoReg_o !== 0 || read_data_o !== 0 ||
            ALU_result_o !== 0 || writeReg_addr_o !== 0 || err_o !== 0) begin
            n_fail++;
            $display("FAIL rst_mid: got req=%b rw=%b m2r=%b rd=%h alu=%h wa=%0d err=%b exp all 0",
                     mem_req_o, RegWrite_o, MemtoReg_o, read_data_o, ALU_result_o,
                     writeReg_addr_o, err_o);
        end
        err_exp = 1'b0;
        drive_idle();
        @(negedge clk_i);
        rst_n = 1;
        mem_ack_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
        @(posedge clk_i); #1;
        mem_ack_i = 0;
        @(negedge clk_i);
        n_checks++;
        if (mem_req_o !== 0 || stall_o !== 0 || read_data_o !== 0 || err_o !== 0) begin
            n_fail++;
            $display("FAIL late_ack: got req=%b stall=%b rd=%h err=%b exp 0 0 0 0",
                     mem_req_o, stall_o, read_data_o, err_o);
        end
        $display("rst_mid: req=%b stall=%b rd=%h err=%b", mem_req_o, stall_o, read_data_o, err_o);
        run_instr("post_rst", 1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0400, 32'h0, 5'd19, 2, 32'h7777_1111);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_timeout();
        test_branch();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
